// File: rtl/mpc_pkg.sv
// Shared definitions for the pad-mux configuration loader.
//   CFG_W_DEF    : default configuration width
//   FRAME_LEN    : serial frame length in bits
//   SYNC_PATTERN : header bits [7:5] of a valid frame
//   state_e      : loader FSM states
//   odd_parity   : parity bit that makes the configuration plus parity odd
package mpc_pkg;

  localparam int CFG_W_DEF = 4;
  localparam int FRAME_LEN = 8;
  localparam logic [2:0] SYNC_PATTERN = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    DRAIN,
    SETTLE
  } state_e;

  function automatic logic odd_parity(input logic [CFG_W_DEF-1:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/mpc_sync.sv
// Multi-stage flop synchronizer for one asynchronous pad input.
//   clk, rst_n : clock, async active-low reset (clears the chain)
//   d          : asynchronous input
//   q          : synchronized output, SYNC_STAGES cycles behind d
module mpc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mpc_cfg_loader.sv
// Serial configuration front end for the multi-project pad mux.
// Receives an 8-bit frame (3-bit header, configuration, odd parity) on three
// asynchronous pads and applies new configurations with a blanking window
// around the switch so no two macros drive a pad at once. The integration
// top ANDs every pad output enable with ~blank.
//   clk, rst_n     : clock, async active-low reset
//   cfg_*_pad      : serial clock, data, active-low frame select (async)
//   err_clr        : clears cfg_err (a simultaneous new error wins)
//   configuration  : current configuration for the pad mux
//   blank          : pad output-enable blanking
//   cfg_valid      : one-cycle pulse when a configuration takes effect
//   cfg_err        : sticky rejected-frame flag
//
// state  | meaning
// IDLE   | waiting for a frame-select falling edge
// SHIFT  | collecting bits on sclk rising edges
// CHECK  | one cycle: validate frame, choose reject / same / switch
// DRAIN  | blanked, old configuration still applied
// SETTLE | blanked, new configuration applied
module mpc_cfg_loader
  import mpc_pkg::*;
#(
  parameter int              CFG_W        = CFG_W_DEF,
  parameter int              SYNC_STAGES  = 2,
  parameter int              BLANK_CYCLES = 16,
  parameter logic [CFG_W-1:0] DEFAULT_CFG = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_sclk_pad,
  input  logic             cfg_sdata_pad,
  input  logic             cfg_csb_pad,
  input  logic             err_clr,
  output logic [CFG_W-1:0] configuration,
  output logic             blank,
  output logic             cfg_valid,
  output logic             cfg_err
);

  localparam int BCNT_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(BLANK_CYCLES - 1);
  localparam logic [3:0] CNT_FULL = 4'(FRAME_LEN);
  localparam logic [3:0] CNT_SAT  = 4'(FRAME_LEN + 1);

  logic sclk_s, sdata_s, csb_s;

  mpc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(cfg_sclk_pad), .q(sclk_s));
  mpc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(clk), .rst_n(rst_n), .d(cfg_sdata_pad), .q(sdata_s));
  mpc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csb (
    .clk(clk), .rst_n(rst_n), .d(cfg_csb_pad), .q(csb_s));

  state_e            state_q, state_d;
  logic              sclk_dly_q, sclk_dly_d;
  logic              csb_dly_q, csb_dly_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic              blank_q, blank_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic sclk_rise, csb_fall, csb_rise, frame_ok;

  always_comb begin
    sclk_rise = sclk_s & ~sclk_dly_q;
    csb_fall  = ~csb_s & csb_dly_q;
    csb_rise  = csb_s & ~csb_dly_q;
    frame_ok  = (cnt_q == CNT_FULL) && (shift_q[7:5] == SYNC_PATTERN) &&
                (shift_q[0] == odd_parity(shift_q[CFG_W:1]));

    sclk_dly_d = sclk_s;
    csb_dly_d  = csb_s;
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    cfg_d      = cfg_q;
    blank_d    = blank_q;
    valid_d    = 1'b0;
    err_d      = err_q & ~err_clr;

    case (state_q)
      IDLE: begin
        if (csb_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (csb_rise) begin
          state_d = CHECK;
        end else if (sclk_rise && !csb_s) begin
          shift_d = {shift_q[6:0], sdata_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!frame_ok) begin
          err_d = 1'b1;
        end else if (shift_q[CFG_W:1] == cfg_q) begin
          valid_d = 1'b1;
        end else begin
          blank_d = 1'b1;
          bcnt_d  = BCNT_LOAD;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bcnt_q == '0) begin
          cfg_d   = shift_q[CFG_W:1];
          bcnt_d  = BCNT_LOAD;
          state_d = SETTLE;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (bcnt_q == '0) begin
          blank_d = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame started while busy is dropped; its csb stays low, so IDLE
    // cannot see a fresh falling edge until the next frame.
    if (csb_fall && (state_q == CHECK || state_q == DRAIN || state_q == SETTLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sclk_dly_q <= 1'b0;
      csb_dly_q  <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      cfg_q      <= DEFAULT_CFG;
      blank_q    <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_dly_q <= sclk_dly_d;
      csb_dly_q  <= csb_dly_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      cfg_q      <= cfg_d;
      blank_q    <= blank_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign configuration = cfg_q;
  assign blank         = blank_q;
  assign cfg_valid     = valid_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_mpc_cfg_loader.sv
// Bench for mpc_cfg_loader: table of frames with expected outcome and
// timeline, a scoreboard of expected valid/error events, and hand-written
// sequences for a collision during blanking and reset during settle.
module tb_mpc_cfg_loader;

  localparam int SYNC = 2;
  localparam int BL   = 16;
  localparam int LAT  = SYNC + 2;
  localparam int WIN  = LAT + 2 * BL + 8;
  localparam int K_ERR  = 0;
  localparam int K_SAME = 1;
  localparam int K_SW   = 2;

  typedef struct {
    logic [15:0] bits;
    int          n;
    int          kind;
    logic [3:0]  cfg;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, sclk, sdata, csb, err_clr;
  logic [3:0] configuration;
  logic       blank, cfg_valid, cfg_err;

  int         n_total = 0;
  int         n_pass  = 0;
  logic [3:0] cur_cfg;
  logic [3:0] exp_valid_q[$];
  logic [3:0] exp_err_q[$];
  vec_t       vecs[7];

  mpc_cfg_loader #(
    .CFG_W(4), .SYNC_STAGES(SYNC), .BLANK_CYCLES(BL), .DEFAULT_CFG(4'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_sclk_pad(sclk), .cfg_sdata_pad(sdata), .cfg_csb_pad(csb),
    .err_clr(err_clr),
    .configuration(configuration), .blank(blank),
    .cfg_valid(cfg_valid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard: pop expected config on each valid pulse / error rise.
  logic       blank_p = 1'b0, err_p = 1'b0;
  logic [3:0] cfg_p = 4'd0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cfg_valid) begin
        if (exp_valid_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_valid: unexpected pulse cfg %0d", configuration);
        end else begin
          chk("sb_valid_cfg", int'(configuration), int'(exp_valid_q.pop_front()));
        end
      end
      if (cfg_err && !err_p) begin
        if (exp_err_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_err: unexpected error cfg %0d", configuration);
        end else begin
          chk("sb_err_cfg", int'(configuration), int'(exp_err_q.pop_front()));
        end
      end
      if (blank != blank_p) chk("blank_cfg_overlap", int'(configuration), int'(cfg_p));
    end
    blank_p = blank;
    err_p   = cfg_err;
    cfg_p   = configuration;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n);
    csb = 1'b0;
    cyc(6);
    for (int i = n - 1; i >= 0; i--) begin
      sdata = bits[i];
      cyc(3);
      sclk = 1'b1;
      cyc(6);
      sclk = 1'b0;
      cyc(3);
    end
    cyc(6);
    csb = 1'b1;
  endtask

  task automatic measure(output int t_br, output int t_cc, output int t_bf,
                         output int t_v, output int t_e);
    logic bp, ep;
    logic [3:0] cp;
    t_br = -1; t_cc = -1; t_bf = -1; t_v = -1; t_e = -1;
    bp = blank; ep = cfg_err; cp = configuration;
    for (int i = 1; i <= WIN; i++) begin
      cyc(1);
      if (blank && !bp && t_br < 0) t_br = i;
      if (!blank && bp && t_bf < 0) t_bf = i;
      if (configuration != cp && t_cc < 0) t_cc = i;
      if (cfg_valid && t_v < 0) t_v = i;
      if (cfg_err && !ep && t_e < 0) t_e = i;
      bp = blank; ep = cfg_err; cp = configuration;
    end
  endtask

  task automatic check_timeline(input string tag, input int kind, input int t_br,
                                input int t_cc, input int t_bf, input int t_v,
                                input int t_e);
    if (kind == K_SW) begin
      chk({tag, "_blank_rise"}, t_br, LAT);
      chk({tag, "_cfg_change"}, t_cc, LAT + BL);
      chk({tag, "_blank_fall"}, t_bf, LAT + 2 * BL);
      chk({tag, "_valid"}, t_v, LAT + 2 * BL);
    end else if (kind == K_SAME) begin
      chk({tag, "_valid"}, t_v, LAT);
      chk({tag, "_no_blank"}, t_br, -1);
    end else begin
      chk({tag, "_err_rise"}, t_e, LAT);
      chk({tag, "_no_blank"}, t_br, -1);
      chk({tag, "_no_valid"}, t_v, -1);
    end
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
    chk({tag, "_err_clr"}, int'(cfg_err), 0);
  endtask

  task automatic do_frame(input logic [15:0] bits, input int n, input int kind,
                          input logic [3:0] cfg, input string tag);
    int t_br, t_cc, t_bf, t_v, t_e;
    if (kind == K_ERR) exp_err_q.push_back(cfg);
    else exp_valid_q.push_back(cfg);
    send_frame(bits, n);
    measure(t_br, t_cc, t_bf, t_v, t_e);
    check_timeline(tag, kind, t_br, t_cc, t_bf, t_v, t_e);
    cur_cfg = cfg;
    chk({tag, "_cfg"}, int'(configuration), int'(cfg));
    chk({tag, "_err"}, int'(cfg_err), (kind == K_ERR) ? 1 : 0);
  endtask

  initial begin
    int t_br, t_cc, t_bf, t_v, t_e, k;

    vecs[0] = '{16'h00AD,  8, K_SW,   4'd6};
    vecs[1] = '{16'h00AC,  8, K_ERR,  4'd6};
    vecs[2] = '{16'h0056,  7, K_ERR,  4'd6};
    vecs[3] = '{16'h015A,  9, K_ERR,  4'd6};
    vecs[4] = '{16'h008D,  8, K_ERR,  4'd6};
    vecs[5] = '{16'h00AD,  8, K_SAME, 4'd6};
    vecs[6] = '{16'h00B3,  8, K_SW,   4'd9};

    sclk = 1'b0; sdata = 1'b0; csb = 1'b1; err_clr = 1'b0; rst_n = 1'b1;
    cur_cfg = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cfg", int'(configuration), 0);
    chk("rst_blank", int'(blank), 0);
    chk("rst_valid", int'(cfg_valid), 0);
    chk("rst_err", int'(cfg_err), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(6);

    for (int i = 0; i < 7; i++) begin
      clear_err($sformatf("vec%0d", i));
      do_frame(vecs[i].bits, vecs[i].n, vecs[i].kind, vecs[i].cfg,
               $sformatf("vec%0d", i));
      cyc(4);
    end

    // New frame started while the switch to config 0 is draining.
    clear_err("coll");
    exp_valid_q.push_back(4'd0);
    exp_err_q.push_back(cur_cfg);
    send_frame(16'h00A1, 8);
    fork
      measure(t_br, t_cc, t_bf, t_v, t_e);
      begin
        cyc(6);
        send_frame(16'h00AD, 8);
      end
    join
    check_timeline("coll", K_SW, t_br, t_cc, t_bf, t_v, t_e);
    cur_cfg = 4'd0;
    chk("coll_cfg", int'(configuration), 0);
    chk("coll_err", int'(cfg_err), 1);
    cyc(4);
    clear_err("after_coll");
    do_frame(16'h00B3, 8, K_SW, 4'd9, "cfg9");
    cyc(4);

    // Reset while settling on config 5.
    send_frame(16'h00AB, 8);
    k = 0;
    while (!blank && k < 2 * LAT) begin cyc(1); k++; end
    chk("rs_blank_seen", int'(blank), 1);
    k = 0;
    while (configuration != 4'd5 && k < 2 * BL) begin cyc(1); k++; end
    chk("rs_settle_cfg", int'(configuration), 5);
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("rs_cfg", int'(configuration), 0);
    chk("rs_blank", int'(blank), 0);
    chk("rs_valid", int'(cfg_valid), 0);
    cyc(2);
    rst_n = 1'b1;
    cur_cfg = 4'd0;
    cyc(6);
    chk("rs_err", int'(cfg_err), 0);
    do_frame(16'h00AD, 8, K_SW, 4'd6, "post_rst");
    cyc(4);

    chk("sb_valid_empty", exp_valid_q.size(), 0);
    chk("sb_err_empty", exp_err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
